// File: rtl/usbreceiver.sv
`default_nettype none
// ============================================================================
// Module   : usbreceiver
// Brief    : FT2232 async 245-FIFO receive path. Strobes RD# while RXF# is
//            low, buffers the bytes in a BRAM FIFO and presents them on a
//            registered show-ahead valid/read interface.
// Revision : 1.0 - initial release
// ============================================================================
module usbreceiver #(
    parameter int FIFO_LOG_SIZE  = 9,
    parameter int RD_LOW_CYCLES  = 4,
    parameter int RD_HIGH_CYCLES = 4
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [7:0] usb_d,
    input  logic       usb_rxf_n,
    output logic       usb_rd_n,
    output logic       usb_wr_n,
    output logic       usb_oe_n,
    input  logic       rx_enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_rd,
    output logic       overflow_guard
);

    localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DEPTH   = 1 << FIFO_LOG_SIZE;

    localparam logic [CNT_W-1:0]         LOW_LOAD  = CNT_W'(RD_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]         HIGH_LOAD = CNT_W'(RD_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_LOG_SIZE-1:0] PTR_ONE   = FIFO_LOG_SIZE'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_LOW  = 2'd1,
        ST_RD_HIGH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     rd_n_q, rd_n_d;
    logic                     rxf_meta_q, rxf_s_q;
    logic [FIFO_LOG_SIZE-1:0] wp_q, wp_d, rp_q, rp_d;
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q;
    logic [7:0]               fifo_mem [DEPTH];

    logic                     wr_en;
    logic                     load;
    logic                     empty;
    logic                     full;
    logic [FIFO_LOG_SIZE-1:0] wp_inc;

    assign wp_inc = wp_q + PTR_ONE;
    assign empty  = (wp_q == rp_q);
    assign full   = (wp_inc == rp_q);

    // Read-strobe sequencer: one FIFO write per completed RD# low phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_n_d  = rd_n_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_n_d = 1'b1;
                // Full is only checked here; a started transfer always has room
                // because the consumer can only free space while it runs.
                if (!rxf_s_q && !full && rx_enable) begin
                    rd_n_d  = 1'b0;
                    cnt_d   = LOW_LOAD;
                    state_d = ST_RD_LOW;
                end
            end
            ST_RD_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Data is captured on the same edge that raises RD#.
                    wr_en   = 1'b1;
                    rd_n_d  = 1'b1;
                    cnt_d   = HIGH_LOAD;
                    state_d = ST_RD_HIGH;
                end
            end
            ST_RD_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                rd_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer and show-ahead output-stage next-state logic.
    always_comb begin
        load        = !empty && (!out_valid_q || out_rd);
        wp_d        = wr_en ? wp_inc : wp_q;
        rp_d        = load ? (rp_q + PTR_ONE) : rp_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_rd && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state; RD# must rise immediately on reset, hence async clear.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            rxf_meta_q  <= 1'b1;
            rxf_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_n_q      <= 1'b1;
            wp_q        <= '0;
            rp_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rxf_meta_q  <= usb_rxf_n;
            rxf_s_q     <= rxf_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_n_q      <= rd_n_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            out_valid_q <= out_valid_d;
        end
    end

    // BRAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            fifo_mem[wp_q] <= usb_d;
        end
    end

    // BRAM registered read port feeding the head-byte register.
    always_ff @(posedge mclk) begin
        if (load) begin
            out_data_q <= fifo_mem[rp_q];
        end
    end

    assign usb_rd_n       = rd_n_q;
    assign usb_wr_n       = 1'b1;
    assign usb_oe_n       = 1'b1;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign overflow_guard = full;

endmodule
`default_nettype wire

// File: tb/tb_usbreceiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_usbreceiver
// Brief    : Directed self-checking bench for usbreceiver (16-entry FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usbreceiver;

    logic       mclk;
    logic       reset;
    logic [7:0] usb_d;
    logic       usb_rxf_n;
    logic       usb_rd_n;
    logic       usb_wr_n;
    logic       usb_oe_n;
    logic       rx_enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_rd;
    logic       overflow_guard;

    int         total = 0;
    int         bad   = 0;

    // FT2232 model: byte k of a test (k = 1, 2, ...) is data_base + k - 1.
    int         fall_cnt  = 0;
    int         fall_ref  = 0;
    logic [7:0] data_base = 8'h00;
    int         cur_low   = 0;
    int         last_low  = 0;
    longint     prev_fall = -1;
    longint     gap_min   = 1000;
    longint     gap_max   = 0;
    logic [7:0] popped [$];

    assign usb_d = data_base + 8'(fall_cnt - fall_ref - 1);

    usbreceiver #(
        .FIFO_LOG_SIZE (4),
        .RD_LOW_CYCLES (4),
        .RD_HIGH_CYCLES(4)
    ) dut (
        .mclk          (mclk),
        .reset         (reset),
        .usb_d         (usb_d),
        .usb_rxf_n     (usb_rxf_n),
        .usb_rd_n      (usb_rd_n),
        .usb_wr_n      (usb_wr_n),
        .usb_oe_n      (usb_oe_n),
        .rx_enable     (rx_enable),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_rd        (out_rd),
        .overflow_guard(overflow_guard)
    );

    initial mclk = 1'b0;
    always #10 mclk = ~mclk;

    // Count read pulses and the spacing between them (in clock periods).
    always @(negedge usb_rd_n) begin
        fall_cnt = fall_cnt + 1;
        if (prev_fall >= 0) begin
            if ((longint'($time) - prev_fall) / 20 < gap_min) gap_min = (longint'($time) - prev_fall) / 20;
            if ((longint'($time) - prev_fall) / 20 > gap_max) gap_max = (longint'($time) - prev_fall) / 20;
        end
        prev_fall = longint'($time);
    end

    // Measure RD# low width and log bytes the consumer pops.
    always @(negedge mclk) begin
        if (!usb_rd_n) begin
            cur_low = cur_low + 1;
        end else if (cur_low != 0) begin
            last_low = cur_low;
            cur_low  = 0;
        end
        if (out_valid && out_rd) popped.push_back(out_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((fall_cnt - fall_ref) < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, fall_cnt - fall_ref, n);
    endtask

    task automatic start_test(input logic [7:0] base);
        data_base = base;
        fall_ref  = fall_cnt;
        popped.delete();
    endtask

    task automatic chk_popped(input string tag, input logic [7:0] base, input int n);
        chk({tag, "_count"}, popped.size(), n);
        for (int i = 0; i < popped.size() && i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), popped[i], base + 8'(i));
        end
    endtask

    initial begin
        reset     = 1'b1;
        usb_rxf_n = 1'b1;
        rx_enable = 1'b1;
        out_rd    = 1'b0;
        #2 reset  = 1'b0;
        tick(3);

        // Reset state
        chk("rst_rd_n", usb_rd_n, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_full", overflow_guard, 1'b0);
        chk("rst_wr_n", usb_wr_n, 1'b1);
        chk("rst_oe_n", usb_oe_n, 1'b1);
        reset = 1'b1;
        tick(3);

        // Single byte with exact strobe timing
        start_test(8'hA5);
        usb_rxf_n = 1'b0;
        tick(2);
        chk("sb_rd_n_e2", usb_rd_n, 1'b1);
        tick(1);
        chk("sb_rd_n_e3", usb_rd_n, 1'b0);
        tick(3);
        chk("sb_rd_n_e6", usb_rd_n, 1'b0);
        tick(1);
        chk("sb_rd_n_e7", usb_rd_n, 1'b1);
        chk("sb_valid_e7", out_valid, 1'b0);
        tick(1);
        chk("sb_valid_e8", out_valid, 1'b1);
        chk("sb_data_e8", out_data, 8'hA5);
        usb_rxf_n = 1'b1;
        tick(30);
        chk("sb_pulses", fall_cnt - fall_ref, 1);
        chk("sb_low_width", last_low, 4);
        chk("sb_valid_hold", out_valid, 1'b1);
        out_rd = 1'b1;
        tick(1);
        out_rd = 1'b0;
        chk("sb_pop_valid", out_valid, 1'b0);
        chk_popped("sb_pop", 8'hA5, 1);

        // Burst of 10 with the consumer always ready
        start_test(8'h00);
        prev_fall = -1;
        gap_min   = 1000;
        gap_max   = 0;
        out_rd    = 1'b1;
        usb_rxf_n = 1'b0;
        wait_pulses(10, 200, "burst_wait");
        usb_rxf_n = 1'b1;
        tick(20);
        out_rd = 1'b0;
        chk("burst_pulses", fall_cnt - fall_ref, 10);
        chk("burst_gap_min", 32'(gap_min), 9);
        chk("burst_gap_max", 32'(gap_max), 9);
        chk_popped("burst", 8'h00, 10);

        // Backpressure: 15 in FIFO plus the output register
        start_test(8'h10);
        usb_rxf_n = 1'b0;
        wait_pulses(16, 250, "bp_wait");
        tick(40);
        chk("bp_pulses", fall_cnt - fall_ref, 16);
        chk("bp_full", overflow_guard, 1'b1);
        chk("bp_rd_n", usb_rd_n, 1'b1);
        chk("bp_head", out_data, 8'h10);
        out_rd = 1'b1;
        tick(1);
        out_rd = 1'b0;
        wait_pulses(17, 30, "bp_refill_wait");
        usb_rxf_n = 1'b1;
        tick(30);
        chk("bp_refill_pulses", fall_cnt - fall_ref, 17);
        chk("bp_refill_full", overflow_guard, 1'b1);
        out_rd = 1'b1;
        tick(20);
        out_rd = 1'b0;
        chk("bp_drain_full", overflow_guard, 1'b0);
        chk("bp_drain_valid", out_valid, 1'b0);
        chk_popped("bp", 8'h10, 17);

        // Pop on the same edge as a FIFO write, 3 bytes already queued
        start_test(8'h40);
        usb_rxf_n = 1'b0;
        wait_pulses(4, 60, "sim_wait");
        usb_rxf_n = 1'b1;
        tick(3);
        out_rd = 1'b1;
        tick(1);
        out_rd = 1'b0;
        chk("sim_edge_rd_n", usb_rd_n, 1'b1);
        chk("sim_head", out_data, 8'h41);
        out_rd = 1'b1;
        tick(10);
        out_rd = 1'b0;
        chk("sim_pulses", fall_cnt - fall_ref, 4);
        chk_popped("sim", 8'h40, 4);

        // rx_enable dropped mid-transfer
        start_test(8'h60);
        usb_rxf_n = 1'b0;
        wait_pulses(1, 20, "en_wait");
        rx_enable = 1'b0;
        tick(40);
        chk("en_off_pulses", fall_cnt - fall_ref, 1);
        chk("en_off_valid", out_valid, 1'b1);
        chk("en_off_data", out_data, 8'h60);
        chk("en_off_rd_n", usb_rd_n, 1'b1);
        rx_enable = 1'b1;
        wait_pulses(2, 10, "en_resume_wait");
        usb_rxf_n = 1'b1;
        tick(12);
        chk("en_resume_pulses", fall_cnt - fall_ref, 2);

        // Reset in cycle 2 of the RD# low phase (output holds a byte)
        chk("rm_pre_valid", out_valid, 1'b1);
        start_test(8'h70);
        usb_rxf_n = 1'b0;
        wait_pulses(1, 20, "rm_wait");
        tick(1);
        chk("rm_pre_rd_n", usb_rd_n, 1'b0);
        #4 reset = 1'b0;
        #1;
        chk("rm_async_rd_n", usb_rd_n, 1'b1);
        chk("rm_async_valid", out_valid, 1'b0);
        tick(2);
        reset = 1'b1;
        wait_pulses(2, 20, "rm_new_wait");
        usb_rxf_n = 1'b1;
        tick(6);
        chk("rm_new_rd_n", usb_rd_n, 1'b1);
        chk("rm_new_low_width", last_low, 4);
        tick(3);
        chk("rm_new_valid", out_valid, 1'b1);
        chk("rm_new_data", out_data, 8'h71);
        out_rd = 1'b1;
        tick(1);
        out_rd = 1'b0;
        chk("rm_pop_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
